// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared port indices, vector type and output state enum for the switch allocator
package noc_pkg;

    localparam int NPORT = 5;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_W = 2;
    localparam int DIR_S = 3;
    localparam int DIR_L = 4;

    typedef logic [NPORT-1:0] port_vec_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_LOCKED
    } out_state_e;

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// rtl/noc_switch_allocator_rr_arbiter.sv - combinational round-robin arbiter, first request at or above ptr wins
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N  = NPORT,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // scan from ptr upward with wrap-around; the first requester found wins
    always_comb begin
        logic found;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// rtl/noc_switch_allocator.sv - credit-based wormhole switch allocator with per-output round-robin
module noc_switch_allocator #(
    parameter int NPORT   = 5,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORT-1:0]             req_valid,
    input  logic [NPORT-1:0][NPORT-1:0]  req_dest,
    input  logic [NPORT-1:0]             req_tail,
    input  logic [NPORT-1:0]             credit_in,
    output logic [NPORT-1:0]             grant,
    output logic [NPORT-1:0]             out_valid,
    output logic [NPORT-1:0][NPORT-1:0]  xbar_sel,
    output logic                         credit_err
);

    import noc_pkg::*;

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    out_state_e          state_q [NPORT];
    out_state_e          state_d [NPORT];
    logic [PW-1:0]       owner_q [NPORT];
    logic [PW-1:0]       owner_d [NPORT];
    logic [PW-1:0]       ptr_q   [NPORT];
    logic [PW-1:0]       ptr_d   [NPORT];
    logic [CW-1:0]       cnt_q   [NPORT];
    logic [CW-1:0]       cnt_d   [NPORT];
    logic                err_q, err_d;

    logic [NPORT-1:0]             dest_ok;
    logic [NPORT-1:0][NPORT-1:0]  cand;    // cand[o][i]: input i wants output o
    logic [NPORT-1:0][NPORT-1:0]  rr_gnt;
    logic [NPORT-1:0][NPORT-1:0]  sel;     // sel[o][i]: input i drives output o this cycle
    logic [NPORT-1:0]             won;
    logic [PW-1:0]                win [NPORT];

    // candidate matrix; malformed destinations (zero or multi-hot) never compete
    always_comb begin
        dest_ok = '0;
        cand    = '0;
        for (int i = 0; i < NPORT; i++) begin
            dest_ok[i] = (req_dest[i] != '0) && ((req_dest[i] & (req_dest[i] - 1'b1)) == '0);
            for (int o = 0; o < NPORT; o++) begin
                cand[o][i] = req_valid[i] & dest_ok[i] & req_dest[i][o];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_arb
            rr_arbiter #(.N(NPORT), .PW(PW)) u_arb (
                .req (cand[g]),
                .ptr (ptr_q[g]),
                .gnt (rr_gnt[g])
            );
        end
    endgenerate

    // per-output selection: arbiter when idle, owner only when locked, nothing without credit
    always_comb begin
        sel   = '0;
        won   = '0;
        grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            win[o] = '0;
            if (!rst && cnt_q[o] != '0) begin
                if (state_q[o] == OUT_IDLE) begin
                    sel[o] = rr_gnt[o];
                end else if (cand[o][owner_q[o]]) begin
                    sel[o][owner_q[o]] = 1'b1;
                end
            end
            won[o] = |sel[o];
            for (int i = 0; i < NPORT; i++) begin
                if (sel[o][i]) begin
                    win[o] = PW'(i);
                end
            end
            grant = grant | sel[o];
        end
        out_valid = won;
        xbar_sel  = sel;
    end

    // next state: lock on non-tail, release and advance pointer on tail, credit bookkeeping
    always_comb begin
        err_d = err_q;
        for (int o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            cnt_d[o]   = cnt_q[o];
            if (won[o]) begin
                if (req_tail[win[o]]) begin
                    state_d[o] = OUT_IDLE;
                    ptr_d[o]   = (win[o] == PW'(NPORT - 1)) ? '0 : win[o] + 1'b1;
                end else begin
                    state_d[o] = OUT_LOCKED;
                    owner_d[o] = win[o];
                end
            end
            if (won[o] && !credit_in[o]) begin
                cnt_d[o] = cnt_q[o] - 1'b1;
            end else if (!won[o] && credit_in[o]) begin
                if (cnt_q[o] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[o] = cnt_q[o] + 1'b1;
                end
            end
        end
    end

    // state registers; reset drops all locks and refills every credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
                cnt_q[o]   <= CW'(CREDITS);
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                cnt_q[o]   <= cnt_d[o];
            end
            err_q <= err_d;
        end
    end

    assign credit_err = err_q;

endmodule
